// File: rtl/oob_dev_pkg.sv
// Shared constants, state encodings and tx-word helpers for the device-side OOB sequencer.
package oob_dev_pkg;

    localparam logic [31:0] ALIGN_P      = 32'h7B4A_4ABC;
    localparam logic [31:0] SYNC_P       = 32'hB5B5_957C;
    localparam logic [3:0]  PRIM_K       = 4'b0001;
    localparam logic [7:0]  PRIM_BYTE0   = 8'h7C;
    localparam int          NONALIGN_CNT = 3;

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_WAIT_RST    = 4'd1;
    localparam logic [3:0] ST_SEND_INIT   = 4'd2;
    localparam logic [3:0] ST_WAIT_WAKE   = 4'd3;
    localparam logic [3:0] ST_SEND_WAKE   = 4'd4;
    localparam logic [3:0] ST_WAIT_ACTIVE = 4'd5;
    localparam logic [3:0] ST_SEND_ALIGN  = 4'd6;
    localparam logic [3:0] ST_SEND_SYNC   = 4'd7;
    localparam logic [3:0] ST_LINKUP      = 4'd8;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  charisk;
    } tx_word_t;

    function automatic logic is_timed(input logic [3:0] st);
        return st inside {ST_SEND_INIT, ST_WAIT_WAKE, ST_SEND_WAKE,
                          ST_WAIT_ACTIVE, ST_SEND_ALIGN, ST_SEND_SYNC};
    endfunction

    function automatic logic tx_active(input logic [3:0] st);
        return st inside {ST_SEND_ALIGN, ST_SEND_SYNC, ST_LINKUP};
    endfunction

    function automatic tx_word_t tx_select(input logic [3:0]  st,
                                           input logic [31:0] data,
                                           input logic [3:0]  charisk);
        tx_word_t w;
        case (st)
            ST_SEND_ALIGN: w = '{data: ALIGN_P, charisk: PRIM_K};
            ST_SEND_SYNC:  w = '{data: SYNC_P,  charisk: PRIM_K};
            ST_LINKUP:     w = '{data: data,    charisk: charisk};
            default:       w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/oob_prim_detect.sv
// Registered ALIGNp detector and consecutive non-ALIGN primitive counter on the rx word stream.
module oob_prim_detect
    import oob_dev_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rxdata_in,
    input  logic [3:0]  rxcharisk_in,
    input  logic        rxbyteisaligned,
    output logic        align_det,
    output logic        nonalign3_det
);

    localparam int CNT_W = $clog2(NONALIGN_CNT + 1);

    logic [CNT_W-1:0] prim_cnt;
    logic [CNT_W-1:0] prim_cnt_nxt;
    logic             is_align;
    logic             is_prim;

    // ALIGNp has byte0 0xBC, so it never qualifies as a non-ALIGN primitive and breaks the run.
    always_comb begin
        is_align     = rxbyteisaligned && (rxcharisk_in == PRIM_K) && (rxdata_in == ALIGN_P);
        is_prim      = rxbyteisaligned && (rxcharisk_in == PRIM_K) && (rxdata_in[7:0] == PRIM_BYTE0);
        // NOTE: default first so every path assigns it; otherwise a latch is inferred.
        prim_cnt_nxt = prim_cnt;
        if (!is_prim) begin
            prim_cnt_nxt = '0;
        end else if (prim_cnt != CNT_W'(NONALIGN_CNT)) begin
            prim_cnt_nxt = prim_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prim_cnt      <= '0;
            align_det     <= 1'b0;
            nonalign3_det <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            prim_cnt      <= prim_cnt_nxt;
            align_det     <= is_align;
            nonalign3_det <= (prim_cnt_nxt == CNT_W'(NONALIGN_CNT));
        end
    end

endmodule

// File: rtl/oob_dev_ctrl.sv
// Device-side SATA OOB responder: answers COMRESET/COMWAKE, then ALIGNp/SYNCp until link-up.
module oob_dev_ctrl
    import oob_dev_pkg::*;
#(
    parameter int DATA_BYTE_WIDTH = 4,
    parameter int CLK_SPEED_GRADE = 1,
    parameter int TIMEOUT_CYCLES  = 65536
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         gtx_ready,
    input  logic                         rxcominitdet_in,
    input  logic                         rxcomwakedet_in,
    input  logic                         rxelecidle_in,
    input  logic                         txcomfinish_in,
    input  logic                         rxbyteisaligned,
    input  logic [DATA_BYTE_WIDTH*8-1:0] rxdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]   rxcharisk_in,
    input  logic [DATA_BYTE_WIDTH*8-1:0] txdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]   txcharisk_in,
    output logic                         txcominit,
    output logic                         txcomwake,
    output logic                         txelecidle,
    output logic [DATA_BYTE_WIDTH*8-1:0] txdata_out,
    output logic [DATA_BYTE_WIDTH-1:0]   txcharisk_out,
    output logic                         phy_ready,
    output logic                         link_up,
    output logic                         oob_error,
    output logic [3:0]                   debug_state
);

    localparam int unsigned LIMIT = TIMEOUT_CYCLES * CLK_SPEED_GRADE;
    localparam int          CNT_W = $clog2(LIMIT + 1);

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             timeout_take;
    logic             restart;
    logic             entering;
    logic             align_det;
    logic             nonalign3_det;
    tx_word_t         tx_nxt;

    oob_prim_detect u_prim_detect (
        .clk             (clk),
        .rst_n           (rst_n),
        .rxdata_in       (rxdata_in),
        .rxcharisk_in    (rxcharisk_in),
        .rxbyteisaligned (rxbyteisaligned),
        .align_det       (align_det),
        .nonalign3_det   (nonalign3_det)
    );

    always_comb begin
        restart      = gtx_ready && rxcominitdet_in && (state != ST_IDLE) && (state != ST_WAIT_RST);
        tmo_hit      = is_timed(state) && (tmo_cnt == CNT_W'(LIMIT - 1));
        state_nxt    = state;
        timeout_take = 1'b0;
        if (!gtx_ready) begin
            state_nxt = ST_IDLE;
        end else if (restart) begin
            state_nxt = ST_SEND_INIT;
        end else if (tmo_hit) begin
            state_nxt    = ST_WAIT_RST;
            timeout_take = 1'b1;
        end else begin
            case (state)
                ST_IDLE:        state_nxt = ST_WAIT_RST;
                ST_WAIT_RST:    if (rxcominitdet_in) state_nxt = ST_SEND_INIT;
                ST_SEND_INIT:   if (txcomfinish_in)  state_nxt = ST_WAIT_WAKE;
                ST_WAIT_WAKE:   if (rxcomwakedet_in) state_nxt = ST_SEND_WAKE;
                ST_SEND_WAKE:   if (txcomfinish_in)  state_nxt = ST_WAIT_ACTIVE;
                ST_WAIT_ACTIVE: if (!rxelecidle_in)  state_nxt = ST_SEND_ALIGN;
                ST_SEND_ALIGN:  if (align_det)       state_nxt = ST_SEND_SYNC;
                ST_SEND_SYNC:   if (nonalign3_det)   state_nxt = ST_LINKUP;
                ST_LINKUP:      state_nxt = ST_LINKUP;
                default:        state_nxt = ST_IDLE;
            endcase
        end
        // A host COMRESET while already in SEND_INIT counts as a fresh entry.
        entering = (state_nxt != state) || restart;
        tx_nxt   = tx_select(state, txdata_in, txcharisk_in);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            tmo_cnt       <= '0;
            txcominit     <= 1'b0;
            txcomwake     <= 1'b0;
            txelecidle    <= 1'b1;
            txdata_out    <= '0;
            txcharisk_out <= '0;
            phy_ready     <= 1'b0;
            link_up       <= 1'b0;
            oob_error     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (entering) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != CNT_W'(LIMIT)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            txcominit     <= entering && (state_nxt == ST_SEND_INIT);
            txcomwake     <= entering && (state_nxt == ST_SEND_WAKE);
            link_up       <= entering && (state_nxt == ST_LINKUP);
            oob_error     <= timeout_take;
            txelecidle    <= !tx_active(state_nxt);
            phy_ready     <= (state_nxt == ST_LINKUP) && gtx_ready && rxbyteisaligned;
            txdata_out    <= tx_nxt.data;
            txcharisk_out <= tx_nxt.charisk;
        end
    end

    assign debug_state = state;

endmodule

// File: tb/tb_oob_dev_ctrl.sv
// Randomized bench for oob_dev_ctrl: pulse scoreboard fed by stimulus, plus level checks.
module tb_oob_dev_ctrl;
    import oob_dev_pkg::*;

    localparam int TMO   = 100;
    localparam int GRADE = 1;
    localparam int LIMIT = TMO * GRADE;
    localparam logic [31:0] EXP_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] EXP_SYNC  = 32'hB5B5957C;

    logic        clk = 1'b0;
    logic        rst_n, gtx_ready, rxcominitdet_in, rxcomwakedet_in, rxelecidle_in;
    logic        txcomfinish_in, rxbyteisaligned;
    logic [31:0] rxdata_in, txdata_in, txdata_out;
    logic [3:0]  rxcharisk_in, txcharisk_in, txcharisk_out, debug_state;
    logic        txcominit, txcomwake, txelecidle, phy_ready, link_up, oob_error;

    oob_dev_ctrl #(.DATA_BYTE_WIDTH(4), .CLK_SPEED_GRADE(GRADE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .gtx_ready(gtx_ready),
        .rxcominitdet_in(rxcominitdet_in), .rxcomwakedet_in(rxcomwakedet_in),
        .rxelecidle_in(rxelecidle_in), .txcomfinish_in(txcomfinish_in),
        .rxbyteisaligned(rxbyteisaligned), .rxdata_in(rxdata_in), .rxcharisk_in(rxcharisk_in),
        .txdata_in(txdata_in), .txcharisk_in(txcharisk_in),
        .txcominit(txcominit), .txcomwake(txcomwake), .txelecidle(txelecidle),
        .txdata_out(txdata_out), .txcharisk_out(txcharisk_out), .phy_ready(phy_ready),
        .link_up(link_up), .oob_error(oob_error), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_INIT = 0, EV_WAKE = 1, EV_LINK = 2, EV_ERR = 3} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       at;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    bit  mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input ev_kind_t kind, input int at);
        exp_q.push_back('{kind: kind, at: at});
    endtask

    // Every one-cycle pulse must match the head of the expected-event queue exactly.
    always @(negedge clk) begin : monitor
        logic [3:0] obs;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_%s: not seen, expected at cycle %0d", exp_q[0].kind.name(), exp_q[0].at);
                void'(exp_q.pop_front());
            end
            obs = {oob_error, link_up, txcomwake, txcominit};
            for (int k = 0; k < 4; k++) begin
                if (obs[k] === 1'b1) begin
                    checks++;
                    if (exp_q.size() > 0 && exp_q[0].at == cyc && exp_q[0].kind == ev_kind_t'(k)) begin
                        void'(exp_q.pop_front());
                    end else begin
                        failures++;
                        $display("FAIL unexpected_%s: seen at cycle %0d, queue depth %0d",
                                 ev_kind_t'(k), cyc, exp_q.size());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish in 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rxcominitdet_in = 1'b0;
        rxcomwakedet_in = 1'b0;
        txcomfinish_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start_init();
        expect_evt(EV_INIT, cyc + 1);
        rxcominitdet_in = 1'b1;
        tick();
        check("state_send_init", debug_state, ST_SEND_INIT);
        check("elecidle_send_init", txelecidle, 1);
    endtask

    task automatic handshake_to_align();
        rxelecidle_in = 1'b1;
        rxdata_in     = '0;
        rxcharisk_in  = '0;
        start_init();
        idle($urandom_range(1, 20));
        txcomfinish_in = 1'b1;
        tick();
        check("state_wait_wake", debug_state, ST_WAIT_WAKE);
        idle($urandom_range(0, 20));
        expect_evt(EV_WAKE, cyc + 1);
        rxcomwakedet_in = 1'b1;
        tick();
        check("state_send_wake", debug_state, ST_SEND_WAKE);
        idle($urandom_range(1, 20));
        txcomfinish_in = 1'b1;
        tick();
        check("state_wait_active", debug_state, ST_WAIT_ACTIVE);
        check("elecidle_wait_active", txelecidle, 1);
        idle($urandom_range(0, 20));
        rxelecidle_in = 1'b0;
        tick();
        check("state_send_align", debug_state, ST_SEND_ALIGN);
        check("elecidle_send_align", txelecidle, 0);
        check("tx_align_latency", txdata_out, 0);
        tick();
        check("tx_align_word", txdata_out, EXP_ALIGN);
        check("tx_align_k", txcharisk_out, 4'b0001);
    endtask

    task automatic align_and_sync(input bit interrupt);
        logic [31:0] wd[$];
        logic [3:0]  wk[$];
        int start, n;
        repeat ($urandom_range(0, 3)) begin
            rxdata_in    = $urandom;
            rxcharisk_in = 4'b0000;
            tick();
        end
        // An ALIGNp seen without byte alignment must be ignored.
        rxdata_in       = EXP_ALIGN;
        rxcharisk_in    = 4'b0001;
        rxbyteisaligned = 1'b0;
        tick();
        rxbyteisaligned = 1'b1;
        wd.push_back(EXP_ALIGN); wk.push_back(4'b0001);
        wd.push_back(EXP_ALIGN); wk.push_back(4'b0001);
        if (interrupt) begin
            wd.push_back(EXP_SYNC);  wk.push_back(4'b0001);
            wd.push_back(EXP_ALIGN); wk.push_back(4'b0001);
        end
        repeat (3) begin
            wd.push_back(EXP_SYNC); wk.push_back(4'b0001);
        end
        start = cyc;
        n     = wd.size();
        expect_evt(EV_LINK, start + n + 1);
        for (int i = 0; i < n; i++) begin
            rxdata_in    = wd[i];
            rxcharisk_in = wk[i];
            tick();
            if (i == 0) check("align_not_yet", debug_state, ST_SEND_ALIGN);
            if (i == 1) check("state_send_sync", debug_state, ST_SEND_SYNC);
            if (i == 2) check("tx_sync_word", txdata_out, EXP_SYNC);
        end
        rxdata_in    = '0;
        rxcharisk_in = '0;
        check("no_early_link", debug_state, ST_SEND_SYNC);
        tick();
        check("state_linkup", debug_state, ST_LINKUP);
        check("phy_ready_up", phy_ready, 1);
        check("elecidle_linkup", txelecidle, 0);
    endtask

    task automatic linkup_pass();
        logic [31:0] d;
        logic [3:0]  k;
        d = 32'h1234_5678;
        k = 4'b0000;
        repeat ($urandom_range(4, 8)) begin
            txdata_in    = d;
            txcharisk_in = k;
            tick();
            check("link_txdata", txdata_out, d);
            check("link_txk", txcharisk_out, k);
            d = $urandom;
            k = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic restart_and_timeout();
        logic [31:0] last;
        int w;
        last = txdata_in;
        start_init();
        check("phy_ready_drop", phy_ready, 0);
        check("tx_lag_restart", txdata_out, last);
        idle($urandom_range(1, 20));
        check("tx_zero_send_init", txdata_out, 0);
        txcomfinish_in = 1'b1;
        tick();
        w = cyc;
        check("state_wait_wake_t", debug_state, ST_WAIT_WAKE);
        expect_evt(EV_ERR, w + LIMIT);
        idle(LIMIT - 1);
        check("pre_timeout", debug_state, ST_WAIT_WAKE);
        tick();
        check("timeout_wait_rst", debug_state, ST_WAIT_RST);
        check("timeout_elecidle", txelecidle, 1);
    endtask

    initial begin : stim
        rst_n = 1'b0; gtx_ready = 1'b1; rxcominitdet_in = 1'b0; rxcomwakedet_in = 1'b0;
        rxelecidle_in = 1'b1; txcomfinish_in = 1'b0; rxbyteisaligned = 1'b1;
        rxdata_in = '0; rxcharisk_in = '0; txdata_in = '0; txcharisk_in = '0;
        tick();
        mon_en = 1'b1;
        idle(2);
        check("rst_state", debug_state, ST_IDLE);
        check("rst_elecidle", txelecidle, 1);
        check("rst_txdata", txdata_out, 0);
        check("rst_txk", txcharisk_out, 0);
        check("rst_phy_ready", phy_ready, 0);
        check("rst_cominit", txcominit, 0);
        rst_n = 1'b1;
        tick();
        check("state_wait_rst", debug_state, ST_WAIT_RST);
        idle($urandom_range(150, 250));
        check("wait_rst_hold", debug_state, ST_WAIT_RST);
        check("wait_rst_elecidle", txelecidle, 1);
        check("wait_rst_txdata", txdata_out, 0);

        for (int it = 0; it < 3; it++) begin
            handshake_to_align();
            align_and_sync(it == 1);
            linkup_pass();
            restart_and_timeout();
        end

        // Completion one slot before the limit advances normally.
        start_init();
        idle(LIMIT - 2);
        txcomfinish_in = 1'b1;
        tick();
        check("finish_before_limit", debug_state, ST_WAIT_WAKE);
        gtx_ready = 1'b0;
        tick();
        check("gtx_drop_idle", debug_state, ST_IDLE);
        gtx_ready = 1'b1;
        tick();
        check("gtx_back_wait_rst", debug_state, ST_WAIT_RST);

        // Completion on the limit cycle loses to the timeout.
        start_init();
        idle(LIMIT - 1);
        expect_evt(EV_ERR, cyc + 1);
        txcomfinish_in = 1'b1;
        tick();
        check("timeout_beats_finish", debug_state, ST_WAIT_RST);

        handshake_to_align();
        gtx_ready = 1'b0;
        tick();
        check("align_gtx_drop_idle", debug_state, ST_IDLE);
        check("align_gtx_drop_elecidle", txelecidle, 1);
        tick();
        check("align_gtx_drop_txdata", txdata_out, 0);
        check("align_gtx_drop_txk", txcharisk_out, 0);
        gtx_ready = 1'b1;
        tick();
        check("align_gtx_back", debug_state, ST_WAIT_RST);

        rst_n = 1'b0;
        rxcominitdet_in = 1'b1;
        tick();
        check("rst_mid_idle", debug_state, ST_IDLE);
        check("rst_mid_no_cominit", txcominit, 0);
        rst_n = 1'b1;
        tick();
        check("rst_mid_wait_rst", debug_state, ST_WAIT_RST);

        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
